// File: rtl/transient_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : transient_pkg                                              |
// | Purpose : Shared types and default constants for the transient       |
// |           softener: FSM state encoding, envelope smoothing shifts,   |
// |           detect threshold and gain-reduction hold length.           |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package transient_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int c_default_width       = 8;
  localparam int c_default_fast_shift  = 2;
  localparam int c_default_slow_shift  = 5;
  localparam int c_default_thresh      = 16;
  localparam int c_default_hold_cycles = 8;

endpackage
`default_nettype wire

// File: rtl/env_follower.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : env_follower                                               |
// | Purpose : First-order envelope tracker. Moves toward the input by    |
// |           the gap shifted right by SHIFT, never by less than 1, so   |
// |           the envelope always lands exactly on a steady input.       |
// | Ports   : clk, rst (sync, active-high), ena (hold when low),         |
// |           sample_in [WIDTH], env_out [WIDTH] (registered envelope)   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module env_follower
  import transient_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int SHIFT = c_default_fast_shift
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] sample_in,
  output logic [WIDTH-1:0] env_out
);

  logic [WIDTH-1:0] env_q;
  logic [WIDTH-1:0] env_d;
  logic [WIDTH-1:0] w_gap;
  logic [WIDTH-1:0] w_step;

  // The step never exceeds the gap, so neither direction can wrap.
  always_comb begin
    env_d  = env_q;
    w_gap  = '0;
    w_step = '0;
    if (sample_in > env_q) begin
      w_gap  = sample_in - env_q;
      w_step = w_gap >> SHIFT;
      if (w_step == '0) w_step = WIDTH'(1);
      env_d  = env_q + w_step;
    end else if (sample_in < env_q) begin
      w_gap  = env_q - sample_in;
      w_step = w_gap >> SHIFT;
      if (w_step == '0) w_step = WIDTH'(1);
      env_d  = env_q - w_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      env_q <= '0;
    end else if (ena) begin
      env_q <= env_d;
    end
  end

  assign env_out = env_q;

endmodule
`default_nettype wire

// File: rtl/transient_softener.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : transient_softener                                         |
// | Purpose : Softens attack transients of an unsigned audio stream.     |
// |           A fast and a slow envelope are compared; when the fast one |
// |           leads by more than THRESH an attack is flagged and a gain  |
// |           reduction is applied, held, then released linearly. An     |
// |           optional sustain cut trims the steady part of the note.    |
// |           Output is the reduced sample rescaled by 1/4.              |
// | Ports   : clk, rst (sync, active-high, beats ena), ena (hold),       |
// |           audio_in [WIDTH], attack_cut, sustain_cut,                 |
// |           audio_out [WIDTH-2] (1-cycle latency), transient_active    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module transient_softener
  import transient_pkg::*;
#(
  parameter int WIDTH       = c_default_width,
  parameter int FAST_SHIFT  = c_default_fast_shift,
  parameter int SLOW_SHIFT  = c_default_slow_shift,
  parameter int THRESH      = c_default_thresh,
  parameter int HOLD_CYCLES = c_default_hold_cycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] audio_in,
  input  logic             attack_cut,
  input  logic             sustain_cut,
  output logic [WIDTH-3:0] audio_out,
  output logic             transient_active
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int EXT_W  = WIDTH + 2;

  logic [WIDTH-1:0]  w_fast_env;
  logic [WIDTH-1:0]  w_slow_env;
  logic [WIDTH-1:0]  w_diff;
  logic              w_det;
  logic [WIDTH-1:0]  w_sr;
  logic signed [EXT_W-1:0] w_sub;
  logic              w_unused_bits;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]  gr_q, gr_d;
  logic [WIDTH-3:0]  audio_out_q, audio_out_d;

  env_follower #(.WIDTH(WIDTH), .SHIFT(FAST_SHIFT)) u_fast_env (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sample_in (audio_in),
    .env_out   (w_fast_env)
  );

  env_follower #(.WIDTH(WIDTH), .SHIFT(SLOW_SHIFT)) u_slow_env (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sample_in (audio_in),
    .env_out   (w_slow_env)
  );

  // Only a rising fast envelope counts as a transient.
  assign w_diff = (w_fast_env > w_slow_env) ? (w_fast_env - w_slow_env) : '0;
  assign w_det  = (int'(w_diff) > THRESH);

  // Sustain trim is suppressed while an attack is being handled.
  assign w_sr = (sustain_cut && ((state_q == ST_IDLE) || (state_q == ST_RELEASE)))
              ? (w_slow_env >> 3) : '0;

  // Two spare bits of headroom make the worst case (0 - gr - sr) representable.
  assign w_sub = $signed({2'b00, audio_in}) - $signed({2'b00, gr_q}) - $signed({2'b00, w_sr});

  // A non-negative result never exceeds audio_in, so the low WIDTH bits hold it.
  assign audio_out_d = w_sub[EXT_W-1] ? '0 : w_sub[WIDTH-1:2];

  assign w_unused_bits = ^{w_sub[EXT_W-2:WIDTH], w_sub[1:0]};

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gr_d       = gr_q;
    unique case (state_q)
      ST_IDLE: begin
        gr_d = '0;
        if (w_det) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        gr_d = attack_cut ? (w_diff >> 1) : '0;
        if (!w_det) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (w_det) begin
          state_d = ST_ATTACK;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      ST_RELEASE: begin
        if (gr_q != '0) gr_d = gr_q - WIDTH'(1);
        if (w_det) begin
          state_d = ST_ATTACK;
        end else if (gr_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      gr_q        <= '0;
      audio_out_q <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gr_q        <= gr_d;
      audio_out_q <= audio_out_d;
    end
  end

  assign audio_out        = audio_out_q;
  assign transient_active = (state_q == ST_ATTACK) || (state_q == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_transient_softener.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_transient_softener                                      |
// | Purpose : Self-checking bench for transient_softener. A behavioural  |
// |           model predicts each registered output; predictions are     |
// |           queued as stimulus is driven and popped after the edge.    |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_transient_softener;
  import transient_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] audio_in = '0;
  logic       attack_cut = 1'b0;
  logic       sustain_cut = 1'b0;
  logic [5:0] audio_out;
  logic       transient_active;

  always #5 clk = ~clk;

  transient_softener dut (
    .clk              (clk),
    .rst              (rst),
    .ena              (ena),
    .audio_in         (audio_in),
    .attack_cut       (attack_cut),
    .sustain_cut      (sustain_cut),
    .audio_out        (audio_out),
    .transient_active (transient_active)
  );

  typedef struct {
    logic [5:0] out;
    logic       ta;
    state_t     st;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  int     m_fast, m_slow, m_gr, m_hold, m_out;
  state_t m_st;

  function automatic int env_next(input int env, input int x, input int sh);
    int d;
    if (x == env) return env;
    d = ((x > env) ? (x - env) : (env - x)) / (1 << sh);
    if (d == 0) d = 1;
    return (x > env) ? env + d : env - d;
  endfunction

  task automatic model_step(input int x, input bit en, input bit r);
    int diff, sr, v;
    bit det;
    if (r) begin
      m_fast = 0; m_slow = 0; m_gr = 0; m_hold = 0; m_out = 0; m_st = ST_IDLE;
      return;
    end
    if (!en) return;
    diff = (m_fast > m_slow) ? m_fast - m_slow : 0;
    det  = diff > 16;
    sr   = (sustain_cut && (m_st == ST_IDLE || m_st == ST_RELEASE)) ? m_slow / 8 : 0;
    v    = x - m_gr - sr;
    m_out = (v < 0) ? 0 : v / 4;
    case (m_st)
      ST_IDLE: begin
        m_gr = 0;
        if (det) m_st = ST_ATTACK;
      end
      ST_ATTACK: begin
        m_gr = attack_cut ? diff / 2 : 0;
        if (!det) begin m_st = ST_HOLD; m_hold = 7; end
      end
      ST_HOLD: begin
        if (det) m_st = ST_ATTACK;
        else if (m_hold == 0) m_st = ST_RELEASE;
        else m_hold = m_hold - 1;
      end
      default: begin
        if (det) m_st = ST_ATTACK;
        else if (m_gr == 0) m_st = ST_IDLE;
        if (m_gr > 0) m_gr = m_gr - 1;
      end
    endcase
    m_fast = env_next(m_fast, x, 2);
    m_slow = env_next(m_slow, x, 5);
  endtask

  // Drives one cycle of stimulus, queues the prediction, returns after the edge.
  task automatic tick(input int x, input bit en, input bit r);
    exp_t e;
    @(negedge clk);
    audio_in = 8'(x);
    ena      = en;
    rst      = r;
    model_step(x, en, r);
    e.out = 6'(m_out);
    e.ta  = (m_st == ST_ATTACK) || (m_st == ST_HOLD);
    e.st  = m_st;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    tick(0, 1, 1);
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t e;
    attack_cut = 1'b1; sustain_cut = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(255, 1, 1);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL reset cyc %0d: out=%0d ta=%0b st=%0d, expected out=%0d ta=%0b st=%0d",
                 i, audio_out, transient_active, dut.state_q, e.out, e.ta, e.st);
      else n_pass++;
    end
    n_checks++;
    if (audio_out !== 6'd0 || transient_active !== 1'b0 || dut.state_q !== ST_IDLE)
      $display("FAIL reset_state: out=%0d ta=%0b st=%0d, expected 0/0/IDLE",
               audio_out, transient_active, dut.state_q);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    exp_t e;
    do_reset();
    attack_cut = 1'b0; sustain_cut = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick(200, 1, 0);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL passthrough cyc %0d: out=%0d ta=%0b st=%0d, expected out=%0d ta=%0b st=%0d",
                 i, audio_out, transient_active, dut.state_q, e.out, e.ta, e.st);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (audio_out !== 6'd50) $display("FAIL passthrough_level cyc %0d: out=%0d, expected 50", i, audio_out);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sustain();
    exp_t e;
    bit   done = 1'b0;
    do_reset();
    attack_cut = 1'b0; sustain_cut = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      tick(200, 1, 0);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL sustain cyc %0d: out=%0d ta=%0b st=%0d, expected out=%0d ta=%0b st=%0d",
                 i, audio_out, transient_active, dut.state_q, e.out, e.ta, e.st);
      else n_pass++;
      if (m_slow == 200 && m_st == ST_IDLE) done = 1'b1;
    end
    tick(200, 1, 0);
    e = sb.pop_front();
    n_checks++;
    if (!done || audio_out !== 6'd43)
      $display("FAIL sustain_level: out=%0d settled=%0b, expected 43 settled=1", audio_out, done);
    else n_pass++;
  endtask

  task automatic test_transient();
    exp_t e;
    int   lat = -1, min_out = 99, hold_run = 0, hold_len = -1;
    bit   idle_seen = 1'b0;
    do_reset();
    attack_cut = 1'b1; sustain_cut = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL transient_settle cyc %0d: out=%0d ta=%0b, expected out=%0d ta=%0b",
                 i, audio_out, transient_active, e.out, e.ta);
      else n_pass++;
    end
    for (int i = 0; i < 400 && !idle_seen; i++) begin
      tick(255, 1, 0);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL transient cyc %0d: out=%0d ta=%0b st=%0d, expected out=%0d ta=%0b st=%0d",
                 i, audio_out, transient_active, dut.state_q, e.out, e.ta, e.st);
      else n_pass++;
      if (lat < 0 && transient_active === 1'b1) lat = i + 1;
      if (dut.state_q == ST_ATTACK && int'(audio_out) < min_out) min_out = int'(audio_out);
      if (dut.state_q == ST_HOLD) hold_run++;
      else if (hold_run > 0) begin
        if (hold_len < 0) hold_len = hold_run;
        hold_run = 0;
      end
      if (lat > 0 && dut.state_q == ST_IDLE) idle_seen = 1'b1;
    end
    n_checks++;
    if (lat < 1 || lat > 3) $display("FAIL transient_latency: cycles=%0d, expected 1..3", lat);
    else n_pass++;
    n_checks++;
    if (min_out >= 63) $display("FAIL attack_reduction: min out=%0d, expected < 63", min_out);
    else n_pass++;
    n_checks++;
    if (hold_len != 8) $display("FAIL hold_length: cycles=%0d, expected 8", hold_len);
    else n_pass++;
    n_checks++;
    if (!idle_seen || dut.gr_q !== 8'd0)
      $display("FAIL release_to_idle: idle=%0b gr=%0d, expected idle=1 gr=0", idle_seen, dut.gr_q);
    else n_pass++;
  endtask

  task automatic test_freeze();
    exp_t   e;
    int     snap_out, snap_hold;
    state_t snap_st;
    bit     reached = 1'b0;
    do_reset();
    attack_cut = 1'b1; sustain_cut = 1'b1;
    for (int i = 0; i < 200 && !reached; i++) begin
      tick((i < 3) ? 0 : 255, 1, 0);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL freeze_lead cyc %0d: out=%0d st=%0d, expected out=%0d st=%0d",
                 i, audio_out, dut.state_q, e.out, e.st);
      else n_pass++;
      if (m_st == ST_HOLD && m_hold == 4) reached = 1'b1;
    end
    snap_out = m_out; snap_hold = m_hold; snap_st = m_st;
    for (int i = 0; i < 10; i++) begin
      tick($urandom_range(0, 255), 0, 0);
      e = sb.pop_front();
      n_checks++;
      if (!reached || int'(audio_out) != snap_out || int'(dut.hold_cnt_q) != snap_hold || dut.state_q !== snap_st)
        $display("FAIL freeze cyc %0d: out=%0d hold=%0d st=%0d, expected out=%0d hold=%0d st=%0d",
                 i, audio_out, dut.hold_cnt_q, dut.state_q, snap_out, snap_hold, snap_st);
      else n_pass++;
    end
    for (int i = 0; i < 40; i++) begin
      tick(255, 1, 0);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL freeze_resume cyc %0d: out=%0d ta=%0b st=%0d, expected out=%0d ta=%0b st=%0d",
                 i, audio_out, transient_active, dut.state_q, e.out, e.ta, e.st);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit   reached = 1'b0;
    do_reset();
    attack_cut = 1'b1; sustain_cut = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      tick((i < 2) ? 0 : 255, 1, 0);
      e = sb.pop_front();
      n_checks++;
      if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
        $display("FAIL mid_reset_lead cyc %0d: out=%0d st=%0d, expected out=%0d st=%0d",
                 i, audio_out, dut.state_q, e.out, e.st);
      else n_pass++;
      if (m_st == ST_ATTACK && m_gr > 0) reached = 1'b1;
    end
    // Reset with enable low: reset must still win.
    tick(255, 0, 1);
    e = sb.pop_front();
    n_checks++;
    if (!reached || dut.state_q !== ST_IDLE || dut.gr_q !== 8'd0 || audio_out !== 6'd0 || transient_active !== 1'b0)
      $display("FAIL mid_reset: reached=%0b st=%0d gr=%0d out=%0d ta=%0b, expected IDLE 0 0 0",
               reached, dut.state_q, dut.gr_q, audio_out, transient_active);
    else n_pass++;
    tick(255, 1, 0);
    e = sb.pop_front();
    n_checks++;
    if (audio_out !== e.out || transient_active !== e.ta || dut.state_q !== e.st)
      $display("FAIL mid_reset_after: out=%0d ta=%0b st=%0d, expected out=%0d ta=%0b st=%0d",
               audio_out, transient_active, dut.state_q, e.out, e.ta, e.st);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_sustain();
    test_transient();
    test_freeze();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/transient_softener.md
TRANSIENT_SOFTENER -- requirements
Module: transient_softener

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input sample width; output width is WIDTH-2.
REQ-002 SHALL have parameter FAST_SHIFT, default 2: fast-envelope smoothing shift.
REQ-003 SHALL have parameter SLOW_SHIFT, default 5: slow-envelope smoothing shift.
REQ-004 SHALL have parameter THRESH, default 16: transient-detect threshold on the envelope difference.
REQ-005 SHALL have parameter HOLD_CYCLES, default 8: gain-reduction hold length, in enabled cycles.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port ena, input, 1: processing enable; when low, all state holds.
REQ-009 SHALL have port audio_in, input, WIDTH: unsigned shaped audio sample.
REQ-010 SHALL have port attack_cut, input, 1: enables transient gain reduction.
REQ-011 SHALL have port sustain_cut, input, 1: enables sustain reduction.
REQ-012 SHALL have port audio_out, output, WIDTH-2: unsigned softened, rescaled sample.
REQ-013 SHALL have port transient_active, output, 1: high when the FSM is in ATTACK or HOLD.

Function
REQ-014 SHALL keep fast_env and slow_env as WIDTH-bit unsigned registers, updated only when ena=1.
REQ-015 Envelope update SHALL be env += max(1,(in-env)>>SHIFT) if in>env; env -= max(1,(env-in)>>SHIFT) if in<env; no change if equal.
REQ-016 SHALL define diff = fast_env - slow_env when fast_env > slow_env, else 0; det = (diff > THRESH). Both use the registered envelopes.
REQ-017 SHALL have FSM states IDLE, ATTACK, HOLD and RELEASE; transitions occur only when ena=1.
REQ-018 IDLE SHALL go to ATTACK when det=1.
REQ-019 ATTACK SHALL stay in ATTACK while det=1; on det=0 it SHALL go to HOLD and load hold_cnt = HOLD_CYCLES-1.
REQ-020 HOLD SHALL go to ATTACK on det=1; otherwise it SHALL go to RELEASE when hold_cnt=0, else decrement hold_cnt.
REQ-021 RELEASE SHALL go to ATTACK on det=1; otherwise it SHALL go to IDLE when gr=0.
REQ-022 Gain reduction gr (WIDTH bits) SHALL be updated as follows:
- in ATTACK: gr <= attack_cut ? diff>>1 : 0;
- in HOLD: gr holds;
- in RELEASE: gr decrements by 1 and saturates at 0;
- in IDLE: gr <= 0.
REQ-023 Sustain reduction SHALL be sr = (sustain_cut && state is IDLE or RELEASE) ? slow_env>>3 : 0, computed combinationally.
REQ-024 When ena=1, audio_out SHALL register max(0, audio_in - gr - sr) >> 2, using gr, sr and the envelopes pre-update; latency is 1 cycle.
REQ-025 The subtraction SHALL use at least WIDTH+2 signed bits and clamp at 0; audio_out SHALL never wrap.
REQ-026 When ena=0, audio_out, the envelopes, gr, hold_cnt and the state SHALL all hold.
REQ-027 transient_active SHALL decode combinationally from the state register.

Reset
REQ-028 When rst=1 at a clock edge, regardless of ena or state, the block SHALL clear audio_out, fast_env, slow_env, gr and hold_cnt to 0 and set state to IDLE.
REQ-029 transient_active SHALL be 0 in the cycle following reset.
REQ-030 rst SHALL take priority over ena.

Structure
REQ-031 A shared package transient_pkg SHALL hold the FSM state enum and the default constants (THRESH, HOLD_CYCLES, shift values).
REQ-032 Envelope update SHALL be one sub-module, env_follower (parameter SHIFT), instantiated twice.

Verification
REQ-033 Reset: hold rst=1 for 2 cycles with audio_in=255 -> audio_out=0, transient_active=0, state IDLE.
REQ-034 Passthrough: attack_cut=0, sustain_cut=0, audio_in=200 steady for 64 cycles -> audio_out=50 every cycle after the first.
REQ-035 Sustain: sustain_cut=1, audio_in=200 steady until slow_env=200 -> audio_out=43.
REQ-036 Transient:
- stimulus: attack_cut=1; audio_in steps 0->255 after settling at 0.
- required: transient_active=1 within 3 cycles; audio_out < 63 while in ATTACK.
- required: HOLD lasts exactly 8 enabled cycles unless det=1 re-triggers.
- required: IDLE is reached after gr decays to 0.
REQ-037 Freeze: ena=0 for 10 cycles mid-HOLD with varying audio_in -> audio_out, hold_cnt and state unchanged; the sequence resumes identically when ena returns to 1.
REQ-038 Mid-operation reset: assert rst for 1 cycle in ATTACK -> next cycle state IDLE, gr=0, audio_out=0.
